viterbi_frame_decoder: RTL
==========================

Name: viterbi_frame_decoder

Overview:
- Parametrised successor of the fixed 16-bit-in / 8-bit-out Viterbi decoder block: rate-1/2 hard-decision decoder for configurable constraint length, generators, input word width, output word width and frame length (in input words).
- Adds valid/ready handshakes on both sides, frame abort/restart, terminated or best-state decision, and an end-of-frame marker.
- Sits between the channel word interface and the byte-oriented consumer.
- Uses a register-exchange survivor memory, one ACS step per cycle.

Parameters:
- IN_W, 16, input word width in bits; must be even. Holds IN_W/2 symbol pairs.
- OUT_W, 8, output word width; L = FRAME_WORDS*IN_W/2 must be a multiple of OUT_W.
- FRAME_WORDS, 1, input words per frame.
- K, 3, constraint length (3..7); NS = 2^(K-1) states.
- G0, 3'b111, generator for symbol bit [1]; width K.
- G1, 3'b101, generator for symbol bit [0]; width K.
- TERMINATED, 1, 1 = decide from state 0; 0 = decide from the best-metric state.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  marks the first word of a frame; qualified by i_valid.
- i_valid  in  1  input word valid.
- i_data  in  IN_W  coded word; pair t = i_data[IN_W-1-2t -: 2], MSB pair first.
- o_ready  out  1  block accepts i_data this cycle.
- o_data  out  OUT_W  decoded bits; earliest bit in MSB.
- o_valid  out  1  o_data valid.
- o_last  out  1  final output word of the frame.
- i_ready  in  1  consumer accepts o_data.

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE; o_valid=0, o_last=0, o_data=0, o_ready=0 in the reset cycle; all metrics, survivors and counters are cleared.
- Reset mid-frame discards the frame. No output is produced.
- Transfers:
  - Input transfer = i_valid & o_ready.
  - Output transfer = o_valid & i_ready.
  - o_data, o_valid and o_last hold stable until accepted.
- FSM states: IDLE, LOAD, ACS, DECIDE, OUT.
- IDLE:
  - o_ready=1.
  - A transfer with i_start=1 loads the word into the symbol shift register, sets metrics (state 0 = 0, others = max), clears survivors and the word count, then goes to ACS.
  - A transfer with i_start=0 is consumed and dropped.
- ACS:
  - One symbol pair per cycle; o_ready=0.
  - Branch metric = Hamming distance (0..2) between the received pair and the expected pair {parity(reg&G0), parity(reg&G1)}.
  - New PM = min over the two predecessors.
  - Tie: lower predecessor index wins.
  - Survivor row = predecessor row shifted left with the decided input bit appended.
  - After pair IN_W/2-1: go to DECIDE if this was word FRAME_WORDS-1, else go to LOAD.
- LOAD:
  - o_ready=1.
  - A transfer with i_start=0 loads the next word and returns to ACS.
  - A transfer with i_start=1 aborts the frame, restarts with this word as word 0, and returns to ACS.
  - i_start=1 is never seen during ACS because o_ready=0 there.
- DECIDE:
  - One cycle.
  - TERMINATED=1: selects state 0.
  - TERMINATED=0: selects the lowest-index state with minimum PM.
  - Latches that L-bit survivor into the output buffer, then goes to OUT.
- OUT:
  - Presents L/OUT_W words, MSB-first from the buffer.
  - o_last=1 on the final word.
  - Advances only on an output transfer. After the final transfer, returns to IDLE.
  - o_ready=0 throughout; no overlap of frames.
- Widths:
  - PM width = clog2(2L+1). Frames are bounded, so no normalisation is needed.
  - Initial "max" = all ones at that width. Saturating add prevents wrap.
- Latency (FRAME_WORDS=1, i_ready=1): first o_valid = IN_W/2 + 2 cycles after the start transfer. For defaults this is 10 cycles.

Decomposition:
- Package viterbi_pkg holds:
  - typedef fsm state enum.
  - functions parity(), bm(), next_state(), predecessor().
  - constant clog2 helper.
- Sub-module viterbi_acs_unit: one state's add-compare-select with tie rule; generated NS times. Outputs new PM and decision bit.
- The top holds the FSM, symbol shifter, survivor register exchange and output serialiser.

Test Plan:
- Defaults, one transfer with i_start=1, i_data=16'hE170 -> one word o_data=8'hB0, o_last=1, 10 cycles after the transfer.
- i_data=16'hC170 (bit 13 flipped) -> o_data=8'hB0 (single error corrected). i_data=16'h0000 -> 8'h00.
- Hold i_ready=0 for 5 cycles after o_valid rises -> o_data=8'hB0 and o_valid held stable, o_ready=0; accepted on the first i_ready=1 cycle, then IDLE with o_ready=1.
- FRAME_WORDS=2:
  - Start word 16'hE170, then word 16'h0000 -> output words 8'hB0 then 8'h00 (o_last on the second).
  - Same, but assert i_start on the second word 16'hE170 -> the first frame is aborted; it is decoded from 16'hE170 as word 0.
- Word with i_start=0 in IDLE -> consumed (o_ready=1), no output. Then i_start word 16'hE170 -> 8'hB0.
- Assert i_rst for 1 cycle mid-ACS -> o_valid=0; o_ready=0 in the reset cycle, then 1. No output for the aborted frame. A following 16'hE170 frame decodes to 8'hB0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the Viterbi frame decoder.
// Trellis state = last K-1 input bits, newest in the MSB; encoder register = {input, state}.
package viterbi_pkg;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACS, S_DECIDE, S_OUT} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits
  function automatic int cw(input int v);
    return (v <= 1) ? 1 : clog2(v);
  endfunction

  function automatic logic parity(input logic [6:0] v);
    return ^v;
  endfunction

  function automatic logic [1:0] bm(input logic [1:0] rx, input logic [1:0] ex);
    logic [1:0] d;
    d = rx ^ ex;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  function automatic logic [5:0] next_state(input logic [5:0] s, input logic u, input int k);
    logic [6:0] r;
    r = {1'b0, s} | (7'(u) << (k - 1));
    return r[6:1];
  endfunction

  // Predecessor b of state n: drop the newest bit, append b as the oldest
  function automatic logic [5:0] predecessor(input logic [5:0] n, input logic b, input int k);
    return {n[4:0], b} & 6'((1 << (k - 1)) - 1);
  endfunction

endpackage

// File: rtl/viterbi_frame_decoder_if.sv
// Channel-side and consumer-side handshake bundle of the Viterbi frame decoder.
interface viterbi_frame_decoder_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  logic             i_start;
  logic             i_valid;
  logic [IN_W-1:0]  i_data;
  logic             o_ready;
  logic [OUT_W-1:0] o_data;
  logic             o_valid;
  logic             o_last;
  logic             i_ready;

  modport slave  (input  i_start, i_valid, i_data, i_ready,
                  output o_ready, o_data, o_valid, o_last);
  modport master (output i_start, i_valid, i_data, i_ready,
                  input  o_ready, o_data, o_valid, o_last);
endinterface

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select for one trellis state; on a tie the lower predecessor wins.
module viterbi_acs_unit #(
  parameter int PMW = 5
) (
  input  logic [PMW-1:0] i_pm0,
  input  logic [PMW-1:0] i_pm1,
  input  logic [1:0]     i_bm0,
  input  logic [1:0]     i_bm1,
  output logic [PMW-1:0] o_pm,
  output logic           o_dec
);
  logic [PMW:0]   w_s0, w_s1;
  logic [PMW-1:0] w_c0, w_c1;

  assign w_s0  = {1'b0, i_pm0} + {{(PMW-1){1'b0}}, i_bm0};
  assign w_s1  = {1'b0, i_pm1} + {{(PMW-1){1'b0}}, i_bm1};
  // Saturate so an unreachable state (all ones) never wraps to a small metric
  assign w_c0  = w_s0[PMW] ? '1 : w_s0[PMW-1:0];
  assign w_c1  = w_s1[PMW] ? '1 : w_s1[PMW-1:0];
  assign o_dec = w_c1 < w_c0;
  assign o_pm  = o_dec ? w_c1 : w_c0;
endmodule

// File: rtl/viterbi_frame_decoder.sv
// Rate-1/2 hard-decision Viterbi frame decoder: FSM, symbol shifter,
// register-exchange survivors and output serialiser.
module viterbi_frame_decoder
  import viterbi_pkg::*;
#(
  parameter int           IN_W        = 16,
  parameter int           OUT_W       = 8,
  parameter int           FRAME_WORDS = 1,
  parameter int           K           = 3,
  parameter logic [K-1:0] G0          = 3'b111,
  parameter logic [K-1:0] G1          = 3'b101,
  parameter int           TERMINATED  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  viterbi_frame_decoder_if.slave bus
);
  localparam int NS   = 1 << (K - 1);
  localparam int NP   = IN_W / 2;
  localparam int L    = FRAME_WORDS * NP;
  localparam int NOUT = L / OUT_W;
  localparam int PMW  = clog2(2 * L + 1);
  localparam int PCW  = cw(NP);
  localparam int WCW  = cw(FRAME_WORDS);
  localparam int OCW  = cw(NOUT);
  localparam int SW   = cw(NS);

  state_t                  r_state, w_next;
  logic [IN_W-1:0]         r_sym;
  logic [PCW-1:0]          r_pair;
  logic [WCW-1:0]          r_word;
  logic [OCW-1:0]          r_ocnt;
  logic [NS-1:0][PMW-1:0]  r_pm, w_pm;
  logic [NS-1:0][L-1:0]    r_surv, w_surv;
  logic [NS-1:0]           w_dec;
  logic [L-1:0]            r_obuf;
  logic [SW-1:0]           w_best;
  logic [1:0]              w_rx;
  logic                    w_in_xfer, w_out_xfer, w_last_pair, w_last_word, w_last_out;

  assign w_rx        = r_sym[IN_W-1 -: 2];
  assign w_in_xfer   = bus.i_valid & bus.o_ready;
  assign w_out_xfer  = bus.o_valid & bus.i_ready;
  assign w_last_pair = r_pair == PCW'(NP - 1);
  assign w_last_word = r_word == WCW'(FRAME_WORDS - 1);
  assign w_last_out  = r_ocnt == OCW'(NOUT - 1);

  assign bus.o_ready = !i_rst && (r_state == S_IDLE || r_state == S_LOAD);
  assign bus.o_valid = !i_rst && (r_state == S_OUT);
  assign bus.o_last  = bus.o_valid && w_last_out;
  assign bus.o_data  = bus.o_valid ? r_obuf[L-1 -: OUT_W] : '0;

  for (genvar n = 0; n < NS; n++) begin : g_state
    localparam int         P0 = int'(predecessor(6'(n), 1'b0, K));
    localparam int         P1 = int'(predecessor(6'(n), 1'b1, K));
    localparam logic [6:0] R0 = 7'(2 * n);
    localparam logic [6:0] R1 = 7'(2 * n + 1);
    localparam logic [1:0] E0 = {parity(R0 & 7'(G0)), parity(R0 & 7'(G1))};
    localparam logic [1:0] E1 = {parity(R1 & 7'(G0)), parity(R1 & 7'(G1))};
    localparam logic       U  = 1'((n >> (K - 2)) & 1);

    viterbi_acs_unit #(.PMW(PMW)) u_acs (
      .i_pm0 (r_pm[P0]),
      .i_pm1 (r_pm[P1]),
      .i_bm0 (bm(w_rx, E0)),
      .i_bm1 (bm(w_rx, E1)),
      .o_pm  (w_pm[n]),
      .o_dec (w_dec[n])
    );

    // Both branches into a state carry the same input bit: its newest state bit
    assign w_surv[n] = w_dec[n] ? {r_surv[P1][L-2:0], U} : {r_surv[P0][L-2:0], U};
  end

  always_comb begin
    w_best = '0;
    if (TERMINATED == 0)
      for (int s = 1; s < NS; s++)
        if (r_pm[s] < r_pm[w_best]) w_best = SW'(s);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_in_xfer && bus.i_start) w_next = S_ACS;
      S_LOAD:   if (w_in_xfer) w_next = S_ACS;
      S_ACS:    if (w_last_pair) w_next = w_last_word ? S_DECIDE : S_LOAD;
      S_DECIDE: w_next = S_OUT;
      S_OUT:    if (w_out_xfer && w_last_out) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sym   <= '0;
      r_pair  <= '0;
      r_word  <= '0;
      r_ocnt  <= '0;
      r_pm    <= '0;
      r_surv  <= '0;
      r_obuf  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_in_xfer && (r_state == S_LOAD || bus.i_start)) begin
            r_sym  <= bus.i_data;
            r_pair <= '0;
            // A start word always begins a fresh frame, also when it arrives mid-frame
            if (bus.i_start) begin
              r_word <= '0;
              r_surv <= '0;
              for (int s = 0; s < NS; s++) r_pm[s] <= (s == 0) ? '0 : '1;
            end
          end
        end
        S_ACS: begin
          r_pm   <= w_pm;
          r_surv <= w_surv;
          r_sym  <= r_sym << 2;
          r_pair <= r_pair + PCW'(1);
          if (w_last_pair) r_word <= r_word + WCW'(1);
        end
        S_DECIDE: begin
          r_obuf <= r_surv[w_best];
          r_ocnt <= '0;
        end
        S_OUT: begin
          if (w_out_xfer) begin
            r_obuf <= r_obuf << OUT_W;
            r_ocnt <= r_ocnt + OCW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
